// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module : bin_to_bcd_seq
// Brief  : Sequential double-dabble binary-to-BCD converter feeding a 4-digit
//          7-segment driver; results held between conversions, "EEEE" > 9999.
// Rev    : 1.0
// ============================================================================
module bin_to_bcd_seq #(
    parameter int BIN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    input  logic [1:0]       frac_digits,
    output logic             busy,
    output logic             done,
    output logic [15:0]      digits,
    output logic [1:0]       ones_place,
    output logic             dp_en,
    output logic             ovf
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [BIN_W-1:0] sr;
    logic [19:0]      acc;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       frac_q;

    logic [19:0]      acc_adj;
    logic [19:0]      acc_shift;
    logic [BIN_W-1:0] sr_shift;
    logic             range_err;
    logic             last_shift;
    logic             unused_adj_msb;

    // Nibble-local add-3 correction ahead of each shift
    generate
        for (genvar i = 0; i < 5; i++) begin : g_adj
            assign acc_adj[4*i +: 4] = (acc[4*i +: 4] >= 4'd5) ? acc[4*i +: 4] + 4'd3
                                                                : acc[4*i +: 4];
        end
    endgenerate

    assign acc_shift      = {acc_adj[18:0], sr[BIN_W-1]};
    assign sr_shift       = sr << 1;
    assign unused_adj_msb = acc_adj[19];
    assign last_shift     = (cnt == CNT_W'(1));
    assign range_err      = (acc_shift[19:16] != 4'd0) || (acc_shift[15:0] > 16'h9999);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_shift) state_next = LOAD;
            LOAD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == SHIFT);
    assign done = (state == LOAD);

    // Result registers are written on the final shift edge so they are
    // already valid during the LOAD cycle that raises done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr         <= '0;
            acc        <= '0;
            cnt        <= '0;
            frac_q     <= '0;
            digits     <= '0;
            ones_place <= '0;
            dp_en      <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sr     <= bin;
                        frac_q <= frac_digits;
                        acc    <= '0;
                        cnt    <= CNT_W'(BIN_W);
                    end
                end
                SHIFT: begin
                    sr  <= sr_shift;
                    acc <= acc_shift;
                    cnt <= cnt - CNT_W'(1);
                    if (last_shift) begin
                        digits     <= range_err ? 16'hEEEE : acc_shift[15:0];
                        ovf        <= range_err;
                        ones_place <= frac_q;
                        dp_en      <= (frac_q != 2'd0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_bin_to_bcd_seq
// Brief  : Self-checking bench for bin_to_bcd_seq (vector table, corner
//          sequences, randomized back-to-back conversions against a model).
// Rev    : 1.0
// ============================================================================
module tb_bin_to_bcd_seq;

    localparam int BIN_W = 16;
    localparam int LAT   = BIN_W + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [BIN_W-1:0] bin;
    logic [1:0]       frac_digits;
    logic             busy;
    logic             done;
    logic [15:0]      digits;
    logic [1:0]       ones_place;
    logic             dp_en;
    logic             ovf;

    int checks   = 0;
    int failures = 0;

    logic [15:0] prev_digits;
    logic [1:0]  prev_op;
    logic        prev_dp;
    logic        prev_ovf;

    typedef struct {
        int          b;
        logic [1:0]  f;
        logic [15:0] d;
        logic [1:0]  op;
        logic        dp;
        logic        ov;
    } vec_t;

    vec_t tbl[6];

    bin_to_bcd_seq #(.BIN_W(BIN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bin        (bin),
        .frac_digits(frac_digits),
        .busy       (busy),
        .done       (done),
        .digits     (digits),
        .ones_place (ones_place),
        .dp_en      (dp_en),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Decimal digit extraction straight from the value; anything above 9999 shows EEEE.
    function automatic void model(input int v, input logic [1:0] f,
                                  output logic [15:0] d, output logic [1:0] op,
                                  output logic dp, output logic ov);
        if (v > 9999) begin
            d  = 16'hEEEE;
            ov = 1'b1;
        end else begin
            d  = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
            ov = 1'b0;
        end
        op = f;
        dp = (f != 2'd0);
    endfunction

    task automatic set_prev(input logic [15:0] d, input logic [1:0] op,
                            input logic dp, input logic ov);
        prev_digits = d;
        prev_op     = op;
        prev_dp     = dp;
        prev_ovf    = ov;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the cycle after done.
    task automatic run_conv(input int b, input logic [1:0] f,
                            input logic [15:0] ed, input logic [1:0] eop,
                            input logic edp, input logic eov);
        int lat;
        bit seen;
        bit steady;
        start       = 1'b1;
        bin         = BIN_W'(b);
        frac_digits = f;
        @(negedge clk);
        start       = 1'b0;
        bin         = BIN_W'($urandom);
        frac_digits = 2'($urandom);
        lat    = 1;
        seen   = 1'b0;
        steady = 1'b1;
        while (!seen && lat <= 40) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (digits !== prev_digits || ones_place !== prev_op ||
                    dp_en !== prev_dp || ovf !== prev_ovf) steady = 1'b0;
                if (busy !== (lat <= BIN_W)) steady = 1'b0;
                @(negedge clk);
                lat++;
            end
        end
        chk("done_latency", 32'(lat), 32'(LAT));
        chk("hold_and_busy", {31'd0, steady}, 32'd1);
        chk("digits", {16'd0, digits}, {16'd0, ed});
        chk("ones_place", {30'd0, ones_place}, {30'd0, eop});
        chk("dp_en_ovf", {30'd0, dp_en, ovf}, {30'd0, edp, eov});
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        set_prev(ed, eop, edp, eov);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    task automatic run_model(input int b, input logic [1:0] f);
        logic [15:0] d;
        logic [1:0]  op;
        logic        dp;
        logic        ov;
        model(b, f, d, op, dp, ov);
        run_conv(b, f, d, op, dp, ov);
    endtask

    initial begin
        tbl[0] = '{b: 1234,  f: 2'd0, d: 16'h1234, op: 2'd0, dp: 1'b0, ov: 1'b0};
        tbl[1] = '{b: 9999,  f: 2'd2, d: 16'h9999, op: 2'd2, dp: 1'b1, ov: 1'b0};
        tbl[2] = '{b: 0,     f: 2'd0, d: 16'h0000, op: 2'd0, dp: 1'b0, ov: 1'b0};
        tbl[3] = '{b: 10000, f: 2'd1, d: 16'hEEEE, op: 2'd1, dp: 1'b1, ov: 1'b1};
        tbl[4] = '{b: 65535, f: 2'd3, d: 16'hEEEE, op: 2'd3, dp: 1'b1, ov: 1'b1};
        tbl[5] = '{b: 42,    f: 2'd0, d: 16'h0042, op: 2'd0, dp: 1'b0, ov: 1'b0};

        rst         = 1'b1;
        start       = 1'b0;
        bin         = '0;
        frac_digits = '0;
        set_prev(16'h0000, 2'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("reset_outputs", {11'd0, busy, done, digits, ones_place, dp_en, ovf}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", {30'd0, busy, done}, 32'd0);

        for (int i = 0; i < 6; i++)
            run_conv(tbl[i].b, tbl[i].f, tbl[i].d, tbl[i].op, tbl[i].dp, tbl[i].ov);

        // start pulses while converting and in LOAD are ignored; the next IDLE cycle accepts
        begin
            int ndone;
            ndone       = 0;
            start       = 1'b1;
            bin         = BIN_W'(5555);
            frac_digits = 2'd1;
            for (int k = 1; k <= LAT; k++) begin
                @(negedge clk);
                start = (k == 3 || k == LAT);
                bin   = BIN_W'(7);
                frac_digits = 2'd0;
                if (done) ndone++;
                if (k == LAT) begin
                    chk("ignore_digits", {16'd0, digits}, 32'h5555);
                    chk("ignore_dp", {29'd0, ones_place, dp_en}, {29'd0, 2'd1, 1'b1});
                end
            end
            chk("ignore_single_done", 32'(ndone), 32'd1);
            @(negedge clk);
            chk("no_second_done", {31'd0, done}, 32'd0);
            chk("ignored_start_not_busy", {31'd0, busy}, 32'd0);
            set_prev(16'h5555, 2'd1, 1'b1, 1'b0);
            run_conv(77, 2'd0, 16'h0077, 2'd0, 1'b0, 1'b0);
        end

        // asynchronous reset in the middle of a conversion
        begin
            bit quiet;
            start       = 1'b1;
            bin         = BIN_W'(8765);
            frac_digits = 2'd2;
            @(negedge clk);
            start = 1'b0;
            repeat (7) @(negedge clk);
            #2 rst = 1'b1;
            #1;
            chk("async_reset", {11'd0, busy, done, digits, ones_place, dp_en, ovf}, 32'd0);
            @(negedge clk);
            rst   = 1'b0;
            quiet = 1'b1;
            for (int k = 0; k < 25; k++) begin
                @(negedge clk);
                if (done || busy || digits !== 16'h0000) quiet = 1'b0;
            end
            chk("no_done_after_reset", {31'd0, quiet}, 32'd1);
            set_prev(16'h0000, 2'd0, 1'b0, 1'b0);
            run_conv(321, 2'd0, 16'h0321, 2'd0, 1'b0, 1'b0);
        end

        // back-to-back randomized conversions against the decimal model
        for (int i = 0; i < 600; i++) begin
            int v;
            if (i % 6 == 5) v = int'($urandom_range(10000, 65535));
            else            v = int'($urandom_range(0, 9999));
            run_model(v, 2'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
